instr_sequencer: RTL and testbench

- Fetch/decode sequencer for the 8-bit CPU; sits directly upstream of the control unit.
- Owns the program counter (PC) and the instruction register (IR).
- Fetches 8-bit instructions from instruction memory over a req/ack handshake, splits each into Opcode[2:0] and Operand[4:0], and pulses En for one cycle per instruction.
- Handles JMP (111) and HLT (000) locally.
- The control unit registers Opcode on En; its outputs are valid in the EXEC cycle that follows.

---
 rtl/instr_sequencer_if.sv | 24 ++
 rtl/instr_sequencer.sv | 115 +++++++++++
 tb/tb_instr_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus: the sequencer drives req/addr, the memory
// answers with ack/data in the cycle the instruction byte is valid.
interface instr_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              Imem_req;
  logic [ADDR_W-1:0] Imem_addr;
  logic              Imem_ack;
  logic [7:0]        Imem_data;

  modport master (
    output Imem_req,
    output Imem_addr,
    input  Imem_ack,
    input  Imem_data
  );

  modport slave (
    input  Imem_req,
    input  Imem_addr,
    output Imem_ack,
    output Imem_data
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode sequencer for the 8-bit CPU: owns PC and IR, handles JMP/HLT.
// Optional single-step mode (PAUSE after every EXEC) is enabled by INSTR_SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  input  logic                Step,
`endif
  instr_sequencer_if.master   imem,
  output logic [2:0]          Opcode,
  output logic [4:0]          Operand,
  output logic                En,
  output logic [ADDR_W-1:0]   Pc,
  output logic                Busy,
  output logic                Halted
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_JMP = 3'b111;

  // One-hot so every status output is a state flop (or an OR of them) and
  // no memory-side input ever reaches an output combinationally.
  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_FETCH  = 6'b000010,
    S_DECODE = 6'b000100,
    S_EXEC   = 6'b001000,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    S_PAUSE  = 6'b100000,
`endif
    S_HALT   = 6'b010000
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        ir_q;

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // pre-edge values; the async reset branch is the only way out of a fetch early.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Start) state_q <= S_FETCH;
        end

        S_FETCH: begin
          if (imem.Imem_ack) begin
            ir_q    <= imem.Imem_data;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (ir_q[7:5] == OP_JMP) pc_q <= ir_q[ADDR_W-1:0];
          else                     pc_q <= pc_q + ADDR_W'(1);
          state_q <= (ir_q[7:5] == OP_HLT) ? S_HALT : S_EXEC;
        end

        S_EXEC: begin
`ifdef INSTR_SEQ_SINGLE_STEP_EN
          state_q <= S_PAUSE;
`else
          state_q <= S_FETCH;
`endif
        end

`ifdef INSTR_SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (Step) state_q <= S_FETCH;
        end
`endif

        // PC already points past the HLT, so a restart resumes there.
        S_HALT: begin
          if (Start) state_q <= S_FETCH;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem.Imem_req  = (state_q == S_FETCH);
  assign imem.Imem_addr = pc_q;

  assign En      = (state_q == S_DECODE);
  assign Halted  = (state_q == S_HALT);
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  assign Busy    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_EXEC)  || (state_q == S_PAUSE);
`else
  assign Busy    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_EXEC);
`endif
  assign Pc      = pc_q;
  assign Opcode  = ir_q[7:5];
  assign Operand = ir_q[4:0];

  // Protocol invariants the control unit and memory rely on.
  a_en_single : assert property (@(posedge Clk) disable iff (Reset) En |=> !En);
  a_req_hold  : assert property (@(posedge Clk) disable iff (Reset)
                  (imem.Imem_req && !imem.Imem_ack) |=> (imem.Imem_req && $stable(imem.Imem_addr)));
  a_halt_idle : assert property (@(posedge Clk) disable iff (Reset) Halted |-> (!Busy && !imem.Imem_req));
  a_req_busy  : assert property (@(posedge Clk) disable iff (Reset) imem.Imem_req |-> (Busy && !En));

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a table of instruction vectors
// driven through a small memory model, plus directed reset/start/step sequences.
module tb_instr_sequencer;
  localparam int ADDR_W = 5;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  localparam int STEP_EXTRA = 1;
`else
  localparam int STEP_EXTRA = 0;
`endif

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Start;
  logic              Step;
  logic [2:0]        Opcode;
  logic [4:0]        Operand;
  logic              En;
  logic [ADDR_W-1:0] Pc;
  logic              Busy;
  logic              Halted;

  instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  instr_sequencer #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    .Step    (Step),
`endif
    .imem    (bus),
    .Opcode  (Opcode),
    .Operand (Operand),
    .En      (En),
    .Pc      (Pc),
    .Busy    (Busy),
    .Halted  (Halted)
  );

  always #5 Clk = ~Clk;

  // Memory model: ack after ack_delay FETCH cycles, or constantly when forced.
  logic [7:0] mem [32];
  int         ack_delay;
  logic       ack_force;
  int         wait_cnt;
  int         cyc = 0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) wait_cnt <= 0;
    else       wait_cnt <= bus.Imem_req ? wait_cnt + 1 : 0;
  end
  always @(posedge Clk) cyc <= cyc + 1;

  assign bus.Imem_ack  = ack_force | (bus.Imem_req & (wait_cnt >= ack_delay));
  assign bus.Imem_data = mem[bus.Imem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         delay;
    bit         tied;
    bit         start;
    logic [2:0] op;
    logic [4:0] opd;
    logic [4:0] next_pc;
    bit         halt;
  } vec_t;

  vec_t vecs [11];
  int   prev_en;

  // Called at the EXEC negedge; in single-step builds walks through PAUSE.
  task automatic pass_pause(input string tag);
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    @(negedge Clk);
    check({tag, " pause_req"},  bus.Imem_req, 0);
    check({tag, " pause_busy"}, Busy, 1);
    check({tag, " pause_en"},   En, 0);
    check({tag, " pause_halt"}, Halted, 0);
    Step = 1'b1;
    @(negedge Clk);
    Step = 1'b0;
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int w = 0;
    while (!bus.Imem_req && w < 10) begin
      @(negedge Clk);
      w++;
    end
    check({tag, " req_seen"}, bus.Imem_req, 1);
  endtask

  task automatic wait_en(input string tag);
    int w = 0;
    while (!En && w < 20) begin
      @(negedge Clk);
      w++;
    end
    check({tag, " en_seen"}, En, 1);
  endtask

  task automatic run_vec(input int idx);
    vec_t  v = vecs[idx];
    string tag = $sformatf("v%0d", idx);
    int    n = 0;
    int    exp_req;
    logic [ADDR_W-1:0] first_addr;
    bit    addr_bad = 0;

    ack_force = v.tied;
    ack_delay = v.delay;
    if (v.start) pulse_start();
    else         pass_pause(tag);
    wait_req(tag);
    first_addr = bus.Imem_addr;
    while (bus.Imem_req && n < 20) begin
      if (bus.Imem_addr !== first_addr) addr_bad = 1;
      n++;
      @(negedge Clk);
    end
    exp_req = v.tied ? 1 : v.delay + 1;
    check({tag, " fetch_addr"},  first_addr, v.addr);
    check({tag, " addr_stable"}, addr_bad, 0);
    check({tag, " req_cycles"},  n, exp_req);
    // DECODE cycle
    check({tag, " en"},      En, 1);
    check({tag, " opcode"},  Opcode, v.op);
    check({tag, " operand"}, Operand, v.opd);
    check({tag, " pc_dec"},  Pc, v.addr);
    check({tag, " busy_dec"}, Busy, 1);
    if (idx > 0 && !v.start)
      check({tag, " en_spacing"}, cyc - prev_en, 3 + (exp_req - 1) + STEP_EXTRA);
    prev_en = cyc;
    @(negedge Clk);
    check({tag, " en_low"},  En, 0);
    check({tag, " pc_next"}, Pc, v.next_pc);
    check({tag, " halted"},  Halted, v.halt);
    check({tag, " busy"},    Busy, !v.halt);
    check({tag, " req_low"}, bus.Imem_req, 0);
    if (v.halt) begin
      repeat (2) begin
        @(negedge Clk);
        check({tag, " halt_noreq"}, bus.Imem_req, 0);
        check({tag, " halt_hold"},  Halted, 1);
        check({tag, " halt_pc"},    Pc, v.next_pc);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          addr   data  dly tied st  op    opd     next   halt
    vecs[0]  = '{5'd0,  8'h45, 0, 1, 1, 3'd2, 5'd5,  5'd1,  0};
    vecs[1]  = '{5'd1,  8'h66, 0, 1, 0, 3'd3, 5'd6,  5'd2,  0};
    vecs[2]  = '{5'd2,  8'hC3, 0, 1, 0, 3'd6, 5'd3,  5'd3,  0};
    vecs[3]  = '{5'd3,  8'h00, 0, 1, 0, 3'd0, 5'd0,  5'd4,  1};
    vecs[4]  = '{5'd4,  8'hF4, 0, 0, 1, 3'd7, 5'd20, 5'd20, 0};
    vecs[5]  = '{5'd20, 8'hFF, 0, 0, 0, 3'd7, 5'd31, 5'd31, 0};
    vecs[6]  = '{5'd31, 8'hA2, 0, 0, 0, 3'd5, 5'd2,  5'd0,  0};
    vecs[7]  = '{5'd0,  8'h45, 3, 0, 0, 3'd2, 5'd5,  5'd1,  0};
    vecs[8]  = '{5'd1,  8'h66, 0, 1, 0, 3'd3, 5'd6,  5'd2,  0};
    vecs[9]  = '{5'd2,  8'hC3, 0, 1, 0, 3'd6, 5'd3,  5'd3,  0};
    vecs[10] = '{5'd3,  8'h00, 0, 1, 0, 3'd0, 5'd0,  5'd4,  1};

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    for (int i = 0; i < 11; i++) mem[vecs[i].addr] = vecs[i].data;

    Reset = 1'b1; Start = 1'b0; Step = 1'b0;
    ack_force = 1'b0; ack_delay = 0; prev_en = 0;
    repeat (2) @(negedge Clk);
    check("rst req",    bus.Imem_req, 0);
    check("rst en",     En, 0);
    check("rst busy",   Busy, 0);
    check("rst halted", Halted, 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst pc",      Pc, 0);
    check("rst opcode",  Opcode, 0);
    check("rst operand", Operand, 0);
    repeat (3) @(negedge Clk);
    check("idle noreq", bus.Imem_req, 0);
    check("idle busy",  Busy, 0);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Start (and Step) held high through FETCH/DECODE from HALT at PC=4.
    ack_force = 1'b0;
    ack_delay = 2;
    Start = 1'b1;
    Step  = 1'b1;
    @(negedge Clk);
    begin
      int n = 0;
      wait_req("hold");
      check("hold addr", bus.Imem_addr, 4);
      while (bus.Imem_req && n < 20) begin
        n++;
        @(negedge Clk);
      end
      check("hold req_cycles", n, 3);
    end
    check("hold en",      En, 1);
    check("hold opcode",  Opcode, 7);
    check("hold operand", Operand, 20);
    Start = 1'b0;
    Step  = 1'b0;
    @(negedge Clk);
    check("hold en_low", En, 0);
    check("hold pc_jmp", Pc, 20);
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    repeat (2) begin
      @(negedge Clk);
      check("step held noreq", bus.Imem_req, 0);
      check("step held busy",  Busy, 1);
    end
    Step = 1'b1;
    @(negedge Clk);
    Step = 1'b0;
`else
    @(negedge Clk);
`endif
    check("jmp fetch req",  bus.Imem_req, 1);
    check("jmp fetch addr", bus.Imem_addr, 20);

    // Asynchronous reset landing in DECODE.
    wait_en("rstdec");
    Reset = 1'b1;
    #1;
    check("rstdec en",     En, 0);
    check("rstdec req",    bus.Imem_req, 0);
    check("rstdec busy",   Busy, 0);
    check("rstdec halted", Halted, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rstdec pc",      Pc, 0);
    check("rstdec opcode",  Opcode, 0);
    check("rstdec operand", Operand, 0);
    repeat (3) @(negedge Clk);
    check("rstdec idle", bus.Imem_req, 0);

`ifdef INSTR_SEQ_SINGLE_STEP_EN
    // Reset while sitting in PAUSE.
    ack_force = 1'b1;
    pulse_start();
    wait_en("rstpause");
    @(negedge Clk);
    @(negedge Clk);
    check("rstpause busy_before", Busy, 1);
    Reset = 1'b1;
    #1;
    check("rstpause busy",  Busy, 0);
    check("rstpause req",   bus.Imem_req, 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("rstpause idle_req",  bus.Imem_req, 0);
    check("rstpause idle_busy", Busy, 0);
    check("rstpause pc",        Pc, 0);
`endif

    // Asynchronous reset during a slow fetch at addr 1.
    ack_force = 1'b0;
    ack_delay = 0;
    pulse_start();
    wait_en("rstfetch");
    @(negedge Clk);
    check("rstfetch pc1", Pc, 1);
    ack_delay = 5;
    pass_pause("rstfetch");
    wait_req("rstfetch");
    @(negedge Clk);
    check("rstfetch req",  bus.Imem_req, 1);
    check("rstfetch addr", bus.Imem_addr, 1);
    Reset = 1'b1;
    #1;
    check("rstfetch req_drop", bus.Imem_req, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rstfetch pc",     Pc, 0);
    check("rstfetch opcode", Opcode, 0);
    check("rstfetch busy",   Busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
